// File: rtl/rename_ctrl.sv
// rename_ctrl: physical-tag free list, map-table write port and single branch checkpoint
module rename_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [19:0]        i_rd4x,
  input  logic [3:0]         i_rd_en,
  input  logic [3:0]         i_br_mask,
  output logic               o_stall,
  output logic               o_we,
  output logic [19:0]        o_waddr4x,
  output logic [4*WIDTH-1:0] o_wdata4x,
  output logic               o_save_en,
  output logic [3:0]         o_save_mask,
  output logic               o_return,
  input  logic [3:0]         i_free_en,
  input  logic [4*WIDTH-1:0] i_free_tag4x,
  input  logic               i_br_ok,
  input  logic               i_mispredict,
  output logic               o_busy,
  output logic [WIDTH-1:0]   o_free_cnt
);
  localparam int DEPTH = 2**WIDTH;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] ring_q [DEPTH];
  logic [WIDTH-1:0] ring_d [DEPTH];
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d, cnt_q, cnt_d, ckpt_q, ckpt_d;
  logic             busy_q, busy_d, fire;
  logic [WIDTH-1:0] need, nsave, apos, fpos, ret_n;
  logic [3:0]       low_br;
  logic [WIDTH+1:0] cnt_sum;
  always_comb begin
    need = '0;
    for (int k = 0; k < 4; k++) need = need + WIDTH'(i_rd_en[k]);
    o_stall = i_valid & ((need > cnt_q) | (|i_br_mask & busy_q) | i_mispredict);
    fire = i_valid & ~o_stall & i_rst_n;
    o_we = fire & |i_rd_en;
    o_save_en = fire & |i_br_mask;
    low_br = i_br_mask & (~i_br_mask + 4'd1);
    o_save_mask = o_save_en ? i_rd_en & (low_br | (low_br - 4'd1)) : 4'b0;
    o_return = i_mispredict & busy_q;
    nsave = '0;
    apos = '0;
    o_waddr4x = '0;
    o_wdata4x = '0;
    for (int k = 0; k < 4; k++) begin
      if (fire && i_rd_en[k]) begin
        o_waddr4x[5*k +: 5] = i_rd4x[5*k +: 5];
        o_wdata4x[WIDTH*k +: WIDTH] = ring_q[head_q + apos];
      end
      apos = apos + WIDTH'(i_rd_en[k]);
      nsave = nsave + WIDTH'(o_save_mask[k]);
    end
    // freed tags are packed contiguously at the tail; tag 0 never enters the ring
    ring_d = ring_q;
    fpos = '0;
    for (int k = 0; k < 4; k++) begin
      if (i_free_en[k] && i_free_tag4x[WIDTH*k +: WIDTH] != '0) begin
        ring_d[tail_q + fpos] = i_free_tag4x[WIDTH*k +: WIDTH];
        fpos = fpos + ONE;
      end
    end
    tail_d = tail_q + fpos;
    ret_n = head_q - ckpt_q;
    head_d = o_return ? ckpt_q : fire ? head_q + need : head_q;
    ckpt_d = o_save_en ? head_q + nsave : ckpt_q;
    busy_d = o_return ? 1'b0 : o_save_en ? 1'b1 : i_br_ok ? 1'b0 : busy_q;
    cnt_sum = (WIDTH+2)'(cnt_q) - (fire ? (WIDTH+2)'(need) : '0) + (WIDTH+2)'(fpos)
            + (o_return ? (WIDTH+2)'(ret_n) : '0);
    cnt_d = cnt_sum[WIDTH-1:0];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) ring_q[k] <= WIDTH'(k + 1);
      head_q <= '0;
      tail_q <= WIDTH'(DEPTH - 1);
      cnt_q  <= WIDTH'(DEPTH - 1);
      ckpt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ckpt_q <= ckpt_d;
      busy_q <= busy_d;
    end
  end
  assign o_busy = busy_q;
  assign o_free_cnt = cnt_q;
  assert property (@(posedge i_clk) disable iff (!i_rst_n) cnt_sum < (WIDTH+2)'(DEPTH));
endmodule
